// File: rtl/mxv_tx_pkg.sv
// Shared types and byte constants for the MxV transmit-side frame sequencer.
// The stop-field values are also used by the receive-side stop check.
package mxv_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ISSUE  = 3'd2,
    S_ARM    = 3'd3,
    S_WAIT   = 3'd4,
    S_FETCH  = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    F_HDR   = 3'd0,
    F_LENB  = 3'd1,
    F_DATA  = 3'd2,
    F_CHK   = 3'd3,
    F_STOP0 = 3'd4,
    F_STOP1 = 3'd5
  } field_t;

  localparam logic [7:0] TX_HEADER = 8'hFE;
  localparam logic [7:0] TX_STOP0  = 8'hEF;
  localparam logic [7:0] TX_STOP1  = 8'hFF;

endpackage

// File: rtl/tx_byte_handshake.sv
// One-byte handshake with the UART transmitter: start pulse, ignored ARM cycle,
// then wait for TXBUSY low. TXDATA holds the last issued byte between issues.
module tx_byte_handshake (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       go,
  input  logic       TXBUSY,
  output logic       TXSTART,
  output logic [7:0] TXDATA,
  output logic       byte_done
);

  logic [7:0] hold_r;
  logic       armed_r;
  logic       waiting_r;

  // Hold register and ARM/WAIT tracking for the byte in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_r    <= 8'h00;
      armed_r   <= 1'b0;
      waiting_r <= 1'b0;
    end else begin
      if (go) begin
        hold_r <= byte_in;
      end
      armed_r <= go;
      if (armed_r) begin
        waiting_r <= 1'b1;
      end else if (byte_done) begin
        waiting_r <= 1'b0;
      end
    end
  end

  // Payload bytes arrive from the buffer in the issue cycle itself, so the
  // issue cycle passes byte_in straight through.
  assign TXSTART   = go;
  assign TXDATA    = go ? byte_in : hold_r;
  assign byte_done = waiting_r & ~TXBUSY;

endmodule

// File: rtl/tx_frame_sequencer.sv
// Response-frame sequencer: HDR, LENB, DATA x len, optional CHK, STOP0, STOP1.
// Optional checksum byte enabled by defining TX_CHECKSUM_EN.
module tx_frame_sequencer
  import mxv_tx_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       SEND,
  input  logic [LEN_W-1:0]           LEN,
  input  logic [7:0]                 RD_DATA,
  input  logic                       TXBUSY,
  output logic [$clog2(MAX_LEN)-1:0] RD_ADDR,
  output logic                       TXSTART,
  output logic [7:0]                 TXDATA,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       UNLOCKFLAG
);

  localparam int AW = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
`ifdef TX_CHECKSUM_EN
  localparam field_t TAIL_FIELD = F_CHK;
`else
  localparam field_t TAIL_FIELD = F_STOP0;
`endif

  state_t           state_r, state_n;
  field_t           field_r, field_n;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt_r;
  logic [LEN_W-1:0] cnt_inc_s;
  logic [AW-1:0]    rd_addr_r;
  logic [7:0]       tx_byte_s;
  logic             issue_s;
  logic             byte_done_s;
  logic             last_data_s;
`ifdef TX_CHECKSUM_EN
  logic [7:0]       chk_r;
`endif

  assign issue_s     = (state_r == S_ISSUE);
  assign cnt_inc_s   = cnt_r + LEN_W'(1);
  assign last_data_s = (cnt_inc_s == len_r);

  // State and field registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      field_r <= F_HDR;
    end else begin
      state_r <= state_n;
      field_r <= field_n;
    end
  end

  // Next state and field advance at the end of each byte handshake.
  always_comb begin
    state_n = state_r;
    field_n = field_r;
    case (state_r)
      S_IDLE: begin
        if (SEND) begin
          state_n = S_LOAD;
          field_n = F_HDR;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_LOAD:  state_n = S_ISSUE;
      S_ISSUE: state_n = S_ARM;
      S_ARM:   state_n = S_WAIT;
      S_WAIT: begin
        if (byte_done_s) begin
          case (field_r)
            F_HDR:   field_n = F_LENB;
            F_LENB:  field_n = (len_r == {LEN_W{1'b0}}) ? TAIL_FIELD : F_DATA;
            F_DATA:  field_n = last_data_s ? TAIL_FIELD : F_DATA;
            F_CHK:   field_n = F_STOP0;
            F_STOP0: field_n = F_STOP1;
            default: field_n = F_HDR;
          endcase
          if (field_r == F_STOP1) begin
            state_n = S_FINISH;
          end else if (field_n == F_DATA) begin
            state_n = S_FETCH;
          end else begin
            state_n = S_ISSUE;
          end
        end else begin
          state_n = S_WAIT;
        end
      end
      S_FETCH:  state_n = S_ISSUE;
      S_FINISH: state_n = S_IDLE;
      default: begin
        state_n = S_IDLE;
        field_n = F_HDR;
      end
    endcase
  end

  // Length capture, payload index and read address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_r     <= {LEN_W{1'b0}};
      cnt_r     <= {LEN_W{1'b0}};
      rd_addr_r <= {AW{1'b0}};
    end else if (state_r == S_IDLE && SEND) begin
      len_r     <= (LEN > MAX_LEN_C) ? MAX_LEN_C : LEN;
      cnt_r     <= {LEN_W{1'b0}};
      rd_addr_r <= {AW{1'b0}};
    end else if (state_r == S_WAIT && byte_done_s && field_r == F_DATA) begin
      cnt_r <= cnt_inc_s;
      if (!last_data_s) begin
        rd_addr_r <= cnt_inc_s[AW-1:0];
      end
    end
  end

`ifdef TX_CHECKSUM_EN
  // Running XOR over the length byte and every payload byte as it issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_r <= 8'h00;
    end else if (state_r == S_LOAD) begin
      chk_r <= 8'h00;
    end else if (issue_s && (field_r == F_LENB || field_r == F_DATA)) begin
      chk_r <= chk_r ^ tx_byte_s;
    end
  end
`endif

  // Byte selected by the current field.
  always_comb begin
    tx_byte_s = 8'h00;
    case (field_r)
      F_HDR:   tx_byte_s = TX_HEADER;
      F_LENB:  tx_byte_s = 8'(len_r);
      F_DATA:  tx_byte_s = RD_DATA;
`ifdef TX_CHECKSUM_EN
      F_CHK:   tx_byte_s = chk_r;
`endif
      F_STOP0: tx_byte_s = TX_STOP0;
      F_STOP1: tx_byte_s = TX_STOP1;
      default: tx_byte_s = 8'h00;
    endcase
  end

  tx_byte_handshake u_handshake (
    .clk       (clk),
    .reset     (reset),
    .byte_in   (tx_byte_s),
    .go        (issue_s),
    .TXBUSY    (TXBUSY),
    .TXSTART   (TXSTART),
    .TXDATA    (TXDATA),
    .byte_done (byte_done_s)
  );

  assign RD_ADDR    = rd_addr_r;
  assign BUSY       = (state_r != S_IDLE);
  assign DONE       = (state_r == S_FINISH);
  assign UNLOCKFLAG = (state_r == S_IDLE);

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Scoreboard bench for tx_frame_sequencer: a frame model queues the expected
// bytes; a monitor thread pops and compares on every TXSTART and DONE.
module tb_tx_frame_sequencer;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int AW      = 4;
`ifdef TX_CHECKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif

  logic             clk;
  logic             reset;
  logic             SEND;
  logic [LEN_W-1:0] LEN;
  logic [7:0]       RD_DATA;
  logic             TXBUSY;
  logic [AW-1:0]    RD_ADDR;
  logic             TXSTART;
  logic [7:0]       TXDATA;
  logic             BUSY;
  logic             DONE;
  logic             UNLOCKFLAG;

  logic [7:0] mem [MAX_LEN];
  int         busy_len;
  int         busy_cnt;

  logic [7:0] exp_q [$];
  int         vectors;
  int         miscompares;
  int         bytes_seen;
  int         max_addr;
  logic       frame_open;
  logic       done_seen;

  tx_frame_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .SEND       (SEND),
    .LEN        (LEN),
    .RD_DATA    (RD_DATA),
    .TXBUSY     (TXBUSY),
    .RD_ADDR    (RD_ADDR),
    .TXSTART    (TXSTART),
    .TXDATA     (TXDATA),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .UNLOCKFLAG (UNLOCKFLAG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result buffer: synchronous read, one cycle latency.
  always @(posedge clk) RD_DATA <= mem[RD_ADDR];

  // UART model: busy for busy_len cycles starting the cycle after TXSTART.
  always @(posedge clk) begin
    if (reset) busy_cnt <= 0;
    else if (TXSTART) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign TXBUSY = (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_txstart"}, {31'b0, TXSTART}, 32'd0);
    check({tag, "_txdata"}, 32'(TXDATA), 32'h00);
    check({tag, "_rd_addr"}, 32'(RD_ADDR), 32'd0);
    check({tag, "_busy"}, {31'b0, BUSY}, 32'd0);
    check({tag, "_done"}, {31'b0, DONE}, 32'd0);
    check({tag, "_unlock"}, {31'b0, UNLOCKFLAG}, 32'd1);
  endtask

  // Reference frame: header, clamped length, buffer bytes, optional XOR, stops.
  task automatic start_frame(input int req_len, input int busy);
    int n;
    logic [7:0] chk;
    n = (req_len > MAX_LEN) ? MAX_LEN : req_len;
    chk = 8'(n);
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mem[i]);
      chk = chk ^ mem[i];
    end
`ifdef TX_CHECKSUM_EN
    exp_q.push_back(chk);
`endif
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hFF);
    busy_len   = busy;
    bytes_seen = 0;
    max_addr   = 0;
    frame_open = 1'b1;
    done_seen  = 1'b0;
    @(negedge clk);
    SEND = 1'b1;
    LEN  = LEN_W'(req_len);
    @(negedge clk);
    SEND = 1'b0;
    LEN  = LEN_W'($urandom_range(0, 31));
    check("load_no_txstart", {31'b0, TXSTART}, 32'd0);
    check("load_busy", {31'b0, BUSY}, 32'd1);
    @(negedge clk);
    check("first_txstart_latency", {31'b0, TXSTART}, 32'd1);
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && !done_seen; i++) @(negedge clk);
    if (!done_seen) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("busy_low_after_done", {31'b0, BUSY}, 32'd0);
    check("unlock_after_done", {31'b0, UNLOCKFLAG}, 32'd1);
  endtask

  task automatic wait_bytes(input int target);
    for (int i = 0; i < 2000 && bytes_seen < target; i++) @(negedge clk);
    if (bytes_seen < target) check("byte_timeout", 32'(bytes_seen), 32'(target));
  endtask

  initial begin
    vectors = 0; miscompares = 0; bytes_seen = 0; max_addr = 0;
    frame_open = 1'b0; done_seen = 1'b0; busy_len = 0;
    SEND = 1'b0; LEN = '0; reset = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) mem[i] = 8'(i);

    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (BUSY && int'(RD_ADDR) > max_addr) max_addr = int'(RD_ADDR);
          if (TXSTART) begin
            bytes_seen++;
            if (exp_q.size() == 0) check("byte_pending", 32'd0, 32'd1);
            else check("txdata", 32'(TXDATA), 32'(exp_q.pop_front()));
          end
          if (DONE) begin
            check("done_all_bytes_sent", 32'(exp_q.size()), 32'd0);
            check("done_single", {31'b0, frame_open}, 32'd1);
            frame_open = 1'b0;
            done_seen  = 1'b1;
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    start_frame(3, 10);
    wait_done(3000);
    check("len3_max_addr", 32'(max_addr), 32'd2);

    start_frame(0, $urandom_range(0, 3));
    wait_done(3000);
    check("len0_rd_addr", 32'(max_addr), 32'd0);

    for (int i = 0; i < MAX_LEN; i++) mem[i] = 8'($urandom);
    start_frame(20, 1);
    wait_done(3000);
    check("len20_max_addr", 32'(max_addr), 32'd15);

    start_frame(6, 2);
    wait_bytes(4);
    @(negedge clk); SEND = 1'b1; LEN = LEN_W'(9);
    @(negedge clk); SEND = 1'b0;
    wait_done(3000);
    repeat (40) @(negedge clk);
    check("resend_no_frame_busy", {31'b0, BUSY}, 32'd0);
    check("resend_byte_count", 32'(bytes_seen), 32'(10 + CHK_BYTES));

    start_frame(4, 0);
    wait_done(3000);
    check("zero_busy_byte_count", 32'(bytes_seen), 32'(8 + CHK_BYTES));

    start_frame(5, 10);
    wait_bytes(4);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    frame_open = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    reset = 1'b0;
    start_frame(2, 3);
    wait_done(3000);

    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < MAX_LEN; i++) mem[i] = 8'($urandom);
      start_frame($urandom_range(0, 20), $urandom_range(0, 4));
      wait_done(3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
